// File: rtl/btb_assoc_predictor.sv
// Set-associative BTB with 2-bit direction counters, round-robin victims and a sequential clear walk.
// Optional same-cycle update-to-lookup bypass enabled by defining BTB_FWD_EN.
module btb_assoc_predictor #(
  parameter int unsigned SETS = 32,
  parameter int unsigned WAYS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  output logic        busy,
  input  logic [31:0] pc_fetch,
  output logic [31:0] predicted_target,
  output logic        prediction_taken,
  output logic        hit,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic        branch_taken,
  input  logic [31:0] update_target
);

  localparam int unsigned IDX = $clog2(SETS);
  localparam int unsigned TW  = 30 - IDX;
  localparam int unsigned PW  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e           state_q, state_d;
  logic [IDX-1:0]   clr_idx_q, clr_idx_d;

  logic             valid_q  [SETS][WAYS];
  logic [TW-1:0]    tag_q    [SETS][WAYS];
  logic [31:0]      target_q [SETS][WAYS];
  logic [1:0]       ctr_q    [SETS][WAYS];
  logic [PW-1:0]    ptr_q    [SETS];

  logic [IDX-1:0]   f_idx, u_idx;
  logic [TW-1:0]    f_tag, u_tag;

  assign f_idx = pc_fetch[IDX+1:2];
  assign f_tag = pc_fetch[31:IDX+2];
  assign u_idx = update_pc[IDX+1:2];
  assign u_tag = update_pc[31:IDX+2];

  // Fetch-side lookup
  logic        lk_hit;
  logic [1:0]  lk_ctr;
  logic [31:0] lk_target;

  always_comb begin
    lk_hit    = 1'b0;
    lk_ctr    = '0;
    lk_target = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[f_idx][PW'(w)] && tag_q[f_idx][PW'(w)] == f_tag) begin
        lk_hit    = 1'b1;
        lk_ctr    = ctr_q[f_idx][PW'(w)];
        lk_target = target_q[f_idx][PW'(w)];
      end
    end
  end

  // Update-side read-modify-write; a miss lands in the set's victim way
  logic          up_hit, up_write;
  logic [PW-1:0] up_way;
  logic [1:0]    up_ctr, new_ctr;
  logic [31:0]   up_target, new_target;

  always_comb begin
    up_hit    = 1'b0;
    up_way    = ptr_q[u_idx];
    up_ctr    = '0;
    up_target = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[u_idx][PW'(w)] && tag_q[u_idx][PW'(w)] == u_tag) begin
        up_hit    = 1'b1;
        up_way    = PW'(w);
        up_ctr    = ctr_q[u_idx][PW'(w)];
        up_target = target_q[u_idx][PW'(w)];
      end
    end
    if (!up_hit) begin
      new_ctr    = 2'b10;
      new_target = update_target;
    end else if (branch_taken) begin
      new_ctr    = (up_ctr == 2'b11) ? 2'b11 : up_ctr + 2'd1;
      new_target = update_target;
    end else begin
      new_ctr    = (up_ctr == 2'b00) ? 2'b00 : up_ctr - 2'd1;
      new_target = up_target;
    end
    up_write = update_en && !busy && (up_hit || branch_taken);
  end

  // Clear-walk FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StClear;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      StClear: begin
        if (flush) begin
          clr_idx_d = '0;
        end else if (clr_idx_q == IDX'(SETS - 1)) begin
          state_d = StIdle;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      StIdle: begin
        if (flush) begin
          state_d   = StClear;
          clr_idx_d = '0;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_comb begin
    busy = (state_q == StClear);
  end

  // Array storage; only valid bits and victim pointers need clearing
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        valid_q[clr_idx_q][PW'(w)] <= 1'b0;
      end
      ptr_q[clr_idx_q] <= '0;
    end else if (up_write) begin
      valid_q[u_idx][up_way]  <= 1'b1;
      tag_q[u_idx][up_way]    <= u_tag;
      target_q[u_idx][up_way] <= new_target;
      ctr_q[u_idx][up_way]    <= new_ctr;
      if (!up_hit) begin
        ptr_q[u_idx] <= (WAYS > 1) ? ptr_q[u_idx] + 1'b1 : '0;
      end
    end
  end

  logic fwd;
`ifdef BTB_FWD_EN
  assign fwd = up_write && (u_idx == f_idx) && (u_tag == f_tag);
`else
  assign fwd = 1'b0;
`endif

  always_comb begin
    hit              = 1'b0;
    prediction_taken = 1'b0;
    predicted_target = pc_fetch + 32'd4;
    if (!busy) begin
      if (fwd) begin
        hit              = 1'b1;
        prediction_taken = new_ctr[1];
        predicted_target = new_target;
      end else if (lk_hit) begin
        hit              = 1'b1;
        prediction_taken = lk_ctr[1];
        predicted_target = lk_target;
      end
    end
  end

endmodule

// File: tb/tb_btb_assoc_predictor.sv
// Self-checking bench for btb_assoc_predictor: directed scenarios plus randomized traffic
// checked against an entry-level reference model.
module tb_btb_assoc_predictor;

  localparam int unsigned SETS = 32;
  localparam int unsigned WAYS = 2;
  localparam int unsigned IDXB = $clog2(SETS);

  logic        clk = 1'b0;
  logic        rst, flush, busy, prediction_taken, hit, update_en, branch_taken;
  logic [31:0] pc_fetch, predicted_target, update_pc, update_target;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  btb_assoc_predictor #(.SETS(SETS), .WAYS(WAYS)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .busy             (busy),
    .pc_fetch         (pc_fetch),
    .predicted_target (predicted_target),
    .prediction_taken (prediction_taken),
    .hit              (hit),
    .update_en        (update_en),
    .update_pc        (update_pc),
    .branch_taken     (branch_taken),
    .update_target    (update_target)
  );

  // Reference model: per-set list of entries plus a remaining-busy-cycles counter
  bit          m_valid [SETS][WAYS];
  logic [31:0] m_tag   [SETS][WAYS];
  logic [31:0] m_tgt   [SETS][WAYS];
  int          m_ctr   [SETS][WAYS];
  int          m_ptr   [SETS];
  int          busy_left;

  function automatic int unsigned set_of(input logic [31:0] pc);
    return (pc >> 2) % SETS;
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (2 + IDXB);
  endfunction

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
  endtask

  task automatic model_update(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
    int s;
    int way;
    s = set_of(pc);
    way = -1;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == tag_of(pc)) way = w;
    if (way >= 0) begin
      if (tk) begin
        m_ctr[s][way] = (m_ctr[s][way] >= 3) ? 3 : m_ctr[s][way] + 1;
        m_tgt[s][way] = tgt;
      end else begin
        m_ctr[s][way] = (m_ctr[s][way] <= 0) ? 0 : m_ctr[s][way] - 1;
      end
    end else if (tk) begin
      way = m_ptr[s];
      m_valid[s][way] = 1'b1;
      m_tag[s][way]   = tag_of(pc);
      m_tgt[s][way]   = tgt;
      m_ctr[s][way]   = 2;
      m_ptr[s]        = (m_ptr[s] + 1) % WAYS;
    end
  endtask

  task automatic model_peek(input logic [31:0] pc, output bit h, output bit tk,
                            output logic [31:0] t);
    int s;
    s  = set_of(pc);
    h  = 1'b0;
    tk = 1'b0;
    t  = pc + 32'd4;
    for (int w = 0; w < WAYS; w++) begin
      if (m_valid[s][w] && m_tag[s][w] == tag_of(pc)) begin
        h  = 1'b1;
        tk = (m_ctr[s][w] >= 2);
        t  = m_tgt[s][w];
      end
    end
  endtask

  task automatic model_expect(output bit h, output bit tk, output logic [31:0] t);
    bit          sv_valid [SETS][WAYS];
    logic [31:0] sv_tag   [SETS][WAYS];
    logic [31:0] sv_tgt   [SETS][WAYS];
    int          sv_ctr   [SETS][WAYS];
    int          sv_ptr   [SETS];
    if (busy_left > 0) begin
      h = 1'b0; tk = 1'b0; t = pc_fetch + 32'd4;
      return;
    end
`ifdef BTB_FWD_EN
    if (update_en && set_of(update_pc) == set_of(pc_fetch) &&
        tag_of(update_pc) == tag_of(pc_fetch)) begin
      sv_valid = m_valid; sv_tag = m_tag; sv_tgt = m_tgt; sv_ctr = m_ctr; sv_ptr = m_ptr;
      model_update(update_pc, branch_taken, update_target);
      model_peek(pc_fetch, h, tk, t);
      m_valid = sv_valid; m_tag = sv_tag; m_tgt = sv_tgt; m_ctr = sv_ctr; m_ptr = sv_ptr;
      return;
    end
`endif
    model_peek(pc_fetch, h, tk, t);
  endtask

  task automatic model_edge();
    if (rst) begin
      busy_left = SETS;
      model_clear();
    end else if (busy_left > 0) begin
      busy_left = flush ? SETS : busy_left - 1;
    end else if (flush) begin
      busy_left = SETS;
      model_clear();
    end else if (update_en) begin
      model_update(update_pc, branch_taken, update_target);
    end
  endtask

  // Advance one clock; inputs are always changed 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; flush = 1'b0; update_en = 1'b0; update_pc = '0;
    branch_taken = 1'b0; update_target = '0; pc_fetch = 32'h100;
    busy_left = SETS;
    model_clear();
    tick(); tick();
    #4;
    vectors++;
    if ({busy, hit, prediction_taken, predicted_target} !== {1'b1, 1'b0, 1'b0, 32'h104}) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b hit=%b taken=%b tgt=%h, want 1 0 0 00000104",
               busy, hit, prediction_taken, predicted_target);
    end
    pc_fetch = 32'hFFFF_FFFC;
    #1;
    vectors++;
    if (predicted_target !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_wrap: got tgt=%h, want 00000000", predicted_target);
    end
    tick();
    rst = 1'b0; pc_fetch = 32'h100;
    for (int k = 0; k < 10; k++) tick();
    // Reassert mid-walk: the walk must restart from set 0
    rst = 1'b1;
    busy_left = SETS;
    model_clear();
    tick();
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < SETS + 8; k++) begin
      #4;
      if (k == 0) begin
        vectors++;
        if ({hit, prediction_taken, predicted_target} !== {1'b0, 1'b0, 32'h104}) begin
          miscompares++;
          $display("FAIL walk_lookup: got hit=%b taken=%b tgt=%h, want 0 0 00000104",
                   hit, prediction_taken, predicted_target);
        end
      end
      if (!busy) break;
      n++;
      tick();
    end
    vectors++;
    if (n != SETS) begin
      miscompares++;
      $display("FAIL reset_busy_len: got %0d cycles, want %0d", n, SETS);
    end
    tick();
  endtask

  task automatic test_allocation();
    update_en = 1'b1; update_pc = 32'h100; branch_taken = 1'b1; update_target = 32'h200;
    pc_fetch = 32'h0;
    tick();
    update_en = 1'b0; pc_fetch = 32'h100;
    #4;
    vectors++;
    if ({hit, prediction_taken, predicted_target} !== {1'b1, 1'b1, 32'h200}) begin
      miscompares++;
      $display("FAIL alloc_hit: got hit=%b taken=%b tgt=%h, want 1 1 00000200",
               hit, prediction_taken, predicted_target);
    end
    tick();
    update_en = 1'b1; update_pc = 32'h300; branch_taken = 1'b0; update_target = 32'h999;
    pc_fetch = 32'h0;
    tick();
    update_en = 1'b0; pc_fetch = 32'h300;
    #4;
    vectors++;
    if ({hit, prediction_taken, predicted_target} !== {1'b0, 1'b0, 32'h304}) begin
      miscompares++;
      $display("FAIL no_alloc_not_taken: got hit=%b taken=%b tgt=%h, want 0 0 00000304",
               hit, prediction_taken, predicted_target);
    end
    tick();
  endtask

  task automatic test_counter();
    bit dir [5];
    bit exp_tk [5];
    dir    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_tk = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      update_en = 1'b1; update_pc = 32'h100; branch_taken = dir[k]; update_target = 32'h200;
      pc_fetch = 32'h0;
      tick();
      update_en = 1'b0; pc_fetch = 32'h100;
      #4;
      vectors++;
      if ({hit, prediction_taken, predicted_target} !== {1'b1, exp_tk[k], 32'h200}) begin
        miscompares++;
        $display("FAIL counter_step%0d: got hit=%b taken=%b tgt=%h, want 1 %b 00000200",
                 k, hit, prediction_taken, predicted_target, exp_tk[k]);
      end
      tick();
    end
  endtask

  task automatic test_replacement();
    logic [31:0] pcs [3];
    logic [32:0] exp_v [3];
    update_en = 1'b1; branch_taken = 1'b1; pc_fetch = 32'h0;
    update_pc = 32'h180; update_target = 32'h1180;
    tick();
    update_pc = 32'h200; update_target = 32'h1200;
    tick();
    update_en = 1'b0;
    pcs   = '{32'h100, 32'h180, 32'h200};
    exp_v = '{{1'b0, 32'h104}, {1'b1, 32'h1180}, {1'b1, 32'h1200}};
    for (int k = 0; k < 3; k++) begin
      pc_fetch = pcs[k];
      #4;
      vectors++;
      if ({hit, predicted_target} !== exp_v[k] || prediction_taken !== exp_v[k][32]) begin
        miscompares++;
        $display("FAIL replace_%h: got hit=%b taken=%b tgt=%h, want hit/taken=%b tgt=%h",
                 pcs[k], hit, prediction_taken, predicted_target, exp_v[k][32], exp_v[k][31:0]);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    int n;
    logic [31:0] pcs [4];
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #4;
      vectors++;
      if (busy !== 1'b1) begin
        miscompares++;
        $display("FAIL flush_busy%0d: got busy=%b, want 1", k, busy);
      end
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    update_en = 1'b1; update_pc = 32'h500; branch_taken = 1'b1; update_target = 32'h600;
    n = 0;
    for (int k = 0; k < SETS + 8; k++) begin
      #4;
      if (!busy) break;
      n++;
      tick();
    end
    update_en = 1'b0;
    vectors++;
    if (n != SETS) begin
      miscompares++;
      $display("FAIL flush_busy_len: got %0d cycles, want %0d", n, SETS);
    end
    tick();
    pcs = '{32'h100, 32'h180, 32'h200, 32'h500};
    for (int k = 0; k < 4; k++) begin
      pc_fetch = pcs[k];
      #4;
      vectors++;
      if ({hit, prediction_taken, predicted_target} !== {1'b0, 1'b0, pcs[k] + 32'd4}) begin
        miscompares++;
        $display("FAIL flushed_%h: got hit=%b taken=%b tgt=%h, want miss", pcs[k], hit,
                 prediction_taken, predicted_target);
      end
      tick();
    end
  endtask

  task automatic test_forwarding();
    logic [33:0] want;
    update_en = 1'b1; update_pc = 32'h100; branch_taken = 1'b1; update_target = 32'h400;
    pc_fetch = 32'h100;
`ifdef BTB_FWD_EN
    want = {1'b1, 1'b1, 32'h400};
`else
    want = {1'b0, 1'b0, 32'h104};
`endif
    #4;
    vectors++;
    if ({hit, prediction_taken, predicted_target} !== want) begin
      miscompares++;
      $display("FAIL fwd_same_cycle: got hit=%b taken=%b tgt=%h, want %b %b %h", hit,
               prediction_taken, predicted_target, want[33], want[32], want[31:0]);
    end
    tick();
    update_en = 1'b0;
    #4;
    vectors++;
    if ({hit, prediction_taken, predicted_target} !== {1'b1, 1'b1, 32'h400}) begin
      miscompares++;
      $display("FAIL fwd_next_cycle: got hit=%b taken=%b tgt=%h, want 1 1 00000400",
               hit, prediction_taken, predicted_target);
    end
    tick();
  endtask

  function automatic logic [31:0] rand_pc();
    return (32'($urandom_range(0, 3)) << (2 + IDXB)) | (32'($urandom_range(0, 1)) << 2) |
           32'($urandom_range(0, 3));
  endfunction

  task automatic test_random();
    bit          e_h, e_tk;
    logic [31:0] e_t;
    for (int k = 0; k < 600; k++) begin
      flush         = ($urandom_range(0, 79) == 0);
      update_en     = $urandom_range(0, 1);
      update_pc     = rand_pc();
      branch_taken  = ($urandom_range(0, 2) != 0);
      update_target = $urandom;
      case ($urandom_range(0, 7))
        0, 1:    pc_fetch = update_pc;
        2:       pc_fetch = $urandom;
        default: pc_fetch = rand_pc();
      endcase
      #4;
      model_expect(e_h, e_tk, e_t);
      vectors++;
      if ({busy, hit, prediction_taken, predicted_target} !==
          {busy_left > 0, e_h, e_tk, e_t}) begin
        miscompares++;
        $display("FAIL random%0d pc=%h: got busy=%b hit=%b taken=%b tgt=%h, want %b %b %b %h",
                 k, pc_fetch, busy, hit, prediction_taken, predicted_target, busy_left > 0,
                 e_h, e_tk, e_t);
      end
      tick();
    end
    flush = 1'b0;
    update_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_allocation();
    test_counter();
    test_replacement();
    test_flush();
    test_forwarding();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
